hpm_counter_csr: RTL and testbench

//  Parametrised Zicntr/Zihpm counter CSR block: cycle, instret, time pass-through, plus NUM_HPM

---
 rtl/hpm_counter_csr.sv | 251 +++++++++++++++++++++++++
 tb/tb_hpm_counter_csr.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hpm_counter_csr.sv
// Zicntr/Zihpm counter CSR block: cycle, instret, time pass-through,
// NUM_HPM programmable event counters, event selectors and mcountinhibit.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   csr_valid/addr/     CSR request, registered on the cycle it arrives;
//   funct3/src/src_nz/  decoded and committed on the following edge
//   rd_nz
//   retire_inst         one instruction retired this cycle
//   wall_time           external real-time counter (read via time/timeh)
//   hpm_event           per-cycle event strobes, selector v counts bit v-1
//   csr_resp_valid      response strobe, one cycle after csr_valid
//   csr_rdata           old CSR value (0 when no read or on exception)
//   csr_exception       illegal-instruction flag for the responded request
//   hpm_overflow        wrap pulses: [0] cycle, [1] instret, [2+i] hpm i
module hpm_counter_csr #(
    parameter int NUM_HPM    = 3,
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_valid,
    input  logic [11:0]           csr_addr,
    input  logic [2:0]            csr_funct3,
    input  logic [31:0]           csr_src,
    input  logic                  csr_src_nz,
    input  logic                  csr_rd_nz,
    input  logic                  retire_inst,
    input  logic [63:0]           wall_time,
    input  logic [NUM_EVENTS-1:0] hpm_event,
    output logic                  csr_resp_valid,
    output logic [31:0]           csr_rdata,
    output logic                  csr_exception,
    output logic [NUM_HPM+1:0]    hpm_overflow
);

    localparam int EW  = $clog2(NUM_EVENTS + 1);
    localparam int EVW = 1 << EW;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [31:0] INH_MASK =
        32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

    // Registered request
    logic        req_v;
    logic [11:0] req_addr;
    logic [2:0]  req_f3;
    logic [31:0] req_src;
    logic        req_src_nz;
    logic        req_rd_nz;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_v <= 1'b0;
        end else begin
            req_v <= csr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (csr_valid) begin
            req_addr   <= csr_addr;
            req_f3     <= csr_funct3;
            req_src    <= csr_src;
            req_src_nz <= csr_src_nz;
            req_rd_nz  <= csr_rd_nz;
        end
    end

    // Architectural state
    logic [CNT_WIDTH-1:0] cyc_cnt;
    logic [CNT_WIDTH-1:0] ir_cnt;
    logic [CNT_WIDTH-1:0] hpm_cnt [NUM_HPM];
    logic [EW-1:0]        evt_sel [NUM_HPM];
    logic [31:0]          inhibit;

    // Address decode
    logic [4:0] lo5;
    logic [4:0] hidx;
    logic       hi;
    logic       is_u;
    logic       is_m;
    logic       is_e;
    logic       hpm_in;
    logic       sel_cyc;
    logic       sel_tim;
    logic       sel_ir;
    logic       sel_hpm;
    logic       sel_evt;
    logic       sel_inh;
    logic       mapped;
    logic       f3_ok;
    logic       op_rw;
    logic       wr_req;
    logic       exc;
    logic       we;
    logic       rd_ok;

    assign lo5    = req_addr[4:0];
    assign hidx   = lo5 - 5'd3;
    assign hi     = req_addr[7];
    assign hpm_in = (lo5 >= 5'd3) && (int'(hidx) < NUM_HPM);

    // Cxx/Bxx counter windows: 00..1F and 80..9F
    assign is_u = (req_addr[11:8] == 4'hC) && (req_addr[6:5] == 2'b00);
    assign is_m = (req_addr[11:8] == 4'hB) && (req_addr[6:5] == 2'b00);
    // 0x320..0x33F: mcountinhibit and mhpmevent
    assign is_e = (req_addr[11:5] == 7'b0011001);

    assign sel_cyc = (is_u | is_m) && (lo5 == 5'd0);
    assign sel_tim = is_u && (lo5 == 5'd1);
    assign sel_ir  = (is_u | is_m) && (lo5 == 5'd2);
    assign sel_hpm = (is_u | is_m) && hpm_in;
    assign sel_evt = is_e && hpm_in;
    assign sel_inh = is_e && (lo5 == 5'd0);
    assign mapped  = sel_cyc | sel_tim | sel_ir | sel_hpm | sel_evt | sel_inh;

    always_comb begin
        f3_ok = 1'b0;
        case (req_f3)
            3'b001, 3'b010, 3'b011,
            3'b101, 3'b110, 3'b111: f3_ok = 1'b1;
            default:                f3_ok = 1'b0;
        endcase
    end

    assign op_rw  = (req_f3[1:0] == 2'b01);
    assign wr_req = op_rw | req_src_nz;
    // User aliases are read-only: any op that would write traps
    assign exc    = ~mapped | ~f3_ok | (is_u & wr_req);
    assign we     = req_v & ~exc & wr_req;
    assign rd_ok  = ~op_rw | req_rd_nz;

    // Old value and merged write value
    logic [63:0]          old64;
    logic [63:0]          wr64;
    logic [31:0]          old32;
    logic [31:0]          new32;
    logic [CNT_WIDTH-1:0] wr_cnt;

    always_comb begin
        old64 = '0;
        if (sel_cyc) old64 = 64'(cyc_cnt);
        if (sel_ir)  old64 = 64'(ir_cnt);
        if (sel_tim) old64 = wall_time;
        for (int i = 0; i < NUM_HPM; i++) begin
            if (sel_hpm && int'(hidx) == i) old64 = 64'(hpm_cnt[i]);
        end
        old32 = hi ? old64[63:32] : old64[31:0];
        for (int i = 0; i < NUM_HPM; i++) begin
            if (sel_evt && int'(hidx) == i) old32 = 32'(evt_sel[i]);
        end
        if (sel_inh) old32 = inhibit;
    end

    always_comb begin
        case (req_f3[1:0])
            2'b10:   new32 = old32 | req_src;
            2'b11:   new32 = old32 & ~req_src;
            default: new32 = req_src;
        endcase
    end

    // Half-write keeps the other 32 bits of the counter
    assign wr64   = hi ? {new32, old64[31:0]} : {old64[63:32], new32};
    assign wr_cnt = wr64[CNT_WIDTH-1:0];

    // Increment enables
    logic [EVW-1:0]     ev_ext;
    logic [NUM_HPM-1:0] hpm_inc;
    logic [NUM_HPM-1:0] hpm_wr;
    logic               cyc_inc;
    logic               ir_inc;
    logic               cyc_wr;
    logic               ir_wr;

    // Bit 0 and bits above NUM_EVENTS stay 0, so selector 0 and
    // out-of-range selectors never count.
    always_comb begin
        ev_ext = '0;
        ev_ext[NUM_EVENTS:1] = hpm_event;
    end

    always_comb begin
        hpm_inc = '0;
        hpm_wr  = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            hpm_inc[i] = ev_ext[evt_sel[i]] & ~inhibit[3+i];
            hpm_wr[i]  = we & sel_hpm & (int'(hidx) == i);
        end
    end

    assign cyc_inc = ~inhibit[0];
    assign ir_inc  = retire_inst & ~inhibit[2];
    assign cyc_wr  = we & sel_cyc;
    assign ir_wr   = we & sel_ir;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt      <= '0;
            ir_cnt       <= '0;
            inhibit      <= '0;
            hpm_overflow <= '0;
            for (int i = 0; i < NUM_HPM; i++) begin
                hpm_cnt[i] <= '0;
                evt_sel[i] <= '0;
            end
        end else begin
            if (cyc_wr) begin
                cyc_cnt <= wr_cnt;
            end else if (cyc_inc) begin
                cyc_cnt <= cyc_cnt + CNT_ONE;
            end
            if (ir_wr) begin
                ir_cnt <= wr_cnt;
            end else if (ir_inc) begin
                ir_cnt <= ir_cnt + CNT_ONE;
            end
            hpm_overflow[0] <= ~cyc_wr & cyc_inc & (&cyc_cnt);
            hpm_overflow[1] <= ~ir_wr & ir_inc & (&ir_cnt);
            for (int i = 0; i < NUM_HPM; i++) begin
                if (hpm_wr[i]) begin
                    hpm_cnt[i] <= wr_cnt;
                end else if (hpm_inc[i]) begin
                    hpm_cnt[i] <= hpm_cnt[i] + CNT_ONE;
                end
                hpm_overflow[2+i] <= ~hpm_wr[i] & hpm_inc[i] & (&hpm_cnt[i]);
                if (we && sel_evt && int'(hidx) == i) begin
                    evt_sel[i] <= new32[EW-1:0];
                end
            end
            if (we && sel_inh) begin
                inhibit <= new32 & INH_MASK;
            end
        end
    end

    // Response
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_resp_valid <= 1'b0;
            csr_rdata      <= '0;
            csr_exception  <= 1'b0;
        end else begin
            csr_resp_valid <= req_v;
            csr_rdata      <= (req_v && !exc && rd_ok) ? old32 : 32'd0;
            csr_exception  <= req_v & exc;
        end
    end

endmodule

// File: tb/tb_hpm_counter_csr.sv
// Directed bench for hpm_counter_csr with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hpm_counter_csr;

    localparam int NUM_HPM    = 3;
    localparam int NUM_EVENTS = 8;
    localparam int CNT_WIDTH  = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  csr_valid;
    logic [11:0]           csr_addr;
    logic [2:0]            csr_funct3;
    logic [31:0]           csr_src;
    logic                  csr_src_nz;
    logic                  csr_rd_nz;
    logic                  retire_inst;
    logic [63:0]           wall_time;
    logic [NUM_EVENTS-1:0] hpm_event;
    logic                  csr_resp_valid;
    logic [31:0]           csr_rdata;
    logic                  csr_exception;
    logic [NUM_HPM+1:0]    hpm_overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hpm_counter_csr #(
        .NUM_HPM    (NUM_HPM),
        .NUM_EVENTS (NUM_EVENTS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .csr_valid      (csr_valid),
        .csr_addr       (csr_addr),
        .csr_funct3     (csr_funct3),
        .csr_src        (csr_src),
        .csr_src_nz     (csr_src_nz),
        .csr_rd_nz      (csr_rd_nz),
        .retire_inst    (retire_inst),
        .wall_time      (wall_time),
        .hpm_event      (hpm_event),
        .csr_resp_valid (csr_resp_valid),
        .csr_rdata      (csr_rdata),
        .csr_exception  (csr_exception),
        .hpm_overflow   (hpm_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, optionally retiring an instruction on the
    // commit edge, and check the response fields.
    task automatic req(input string tag, input logic [11:0] a,
                       input logic [2:0] f3, input logic [31:0] src,
                       input logic src_nz, input logic rd_nz,
                       input logic ret, input logic [31:0] exp_rd,
                       input logic exp_ex);
        csr_valid  = 1'b1;
        csr_addr   = a;
        csr_funct3 = f3;
        csr_src    = src;
        csr_src_nz = src_nz;
        csr_rd_nz  = rd_nz;
        @(negedge clk);
        chk({tag, "_early"}, 64'(csr_resp_valid), 64'd0);
        csr_valid   = 1'b0;
        retire_inst = ret;
        @(negedge clk);
        retire_inst = 1'b0;
        chk({tag, "_vld"}, 64'(csr_resp_valid), 64'd1);
        chk({tag, "_rd"}, 64'(csr_rdata), 64'(exp_rd));
        chk({tag, "_exc"}, 64'(csr_exception), 64'(exp_ex));
    endtask

    // CSRRS with rs1=x0: pure read
    task automatic rd(input string tag, input logic [11:0] a,
                      input logic [31:0] exp);
        req(tag, a, 3'b010, 32'd0, 1'b0, 1'b1, 1'b0, exp, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        csr_valid   = 1'b0;
        csr_addr    = '0;
        csr_funct3  = '0;
        csr_src     = '0;
        csr_src_nz  = 1'b0;
        csr_rd_nz   = 1'b0;
        retire_inst = 1'b0;
        wall_time   = 64'h1234_5678_9ABC_DEF0;
        hpm_event   = '0;
        repeat (3) @(negedge clk);
        chk("rst_vld", 64'(csr_resp_valid), 64'd0);
        chk("rst_rdata", 64'(csr_rdata), 64'd0);
        chk("rst_exc", 64'(csr_exception), 64'd0);
        chk("rst_ovf", 64'(hpm_overflow), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Cycle read after 10 idle cycles; RS with src_nz=0 must not write
        req("t1_cyc", 12'hC00, 3'b010, 32'hFFFF_0000, 1'b0, 1'b1, 1'b0,
            32'd11, 1'b0);
        rd("t1_cyc2", 12'hC00, 32'd13);

        // hpm0 preset near all-ones, then wraps on event 0
        hpm_event = 8'h01;
        req("t2_lo", 12'hB03, 3'b001, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0,
            32'd0, 1'b0);
        req("t2_hi", 12'hB83, 3'b001, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0,
            32'd0, 1'b0);
        req("t2_sel", 12'h323, 3'b001, 32'd1, 1'b1, 1'b1, 1'b0,
            32'd0, 1'b0);
        @(negedge clk);
        chk("t2_ovf_pre", 64'(hpm_overflow), 64'd0);
        @(negedge clk);
        chk("t2_ovf", 64'(hpm_overflow), 64'b00100);
        hpm_event = '0;
        @(negedge clk);
        chk("t2_ovf_post", 64'(hpm_overflow), 64'd0);
        rd("t2_rlo", 12'hB03, 32'd0);
        rd("t2_rhi", 12'hB83, 32'd0);

        // hpm1 on event 2 for four cycles
        req("th1_sel", 12'h324, 3'b001, 32'd3, 1'b1, 1'b1, 1'b0,
            32'd0, 1'b0);
        hpm_event = 8'h04;
        repeat (4) @(negedge clk);
        hpm_event = '0;
        rd("th1_cnt", 12'hB04, 32'd4);
        rd("th1_ucnt", 12'hC04, 32'd4);

        // Writes to user aliases trap
        req("t3_rw", 12'hC02, 3'b001, 32'd5, 1'b1, 1'b1, 1'b0,
            32'd0, 1'b1);
        req("t3_rs1", 12'hC02, 3'b010, 32'd1, 1'b1, 1'b1, 1'b0,
            32'd0, 1'b1);
        rd("t3_rs0", 12'hC02, 32'd0);
        rd("t3_mir", 12'hB02, 32'd0);

        // Write beats a simultaneous retire
        req("t5_wr", 12'hB02, 3'b001, 32'd100, 1'b1, 1'b1, 1'b1,
            32'd0, 1'b0);
        rd("t5_rd", 12'hB02, 32'd100);
        retire_inst = 1'b1;
        repeat (3) @(negedge clk);
        retire_inst = 1'b0;
        rd("t5_inc", 12'hB02, 32'd103);
        req("t5_rdnz0", 12'hB02, 3'b001, 32'd200, 1'b1, 1'b0, 1'b0,
            32'd0, 1'b0);
        rd("t5_rd2", 12'hC02, 32'd200);

        // Cycle inhibit freezes, clearing it resumes
        req("t4_set", 12'h320, 3'b110, 32'd1, 1'b1, 1'b1, 1'b0,
            32'd0, 1'b0);
        req("t4_wcyc", 12'hB00, 3'b001, 32'd1000, 1'b1, 1'b0, 1'b0,
            32'd0, 1'b0);
        rd("t4_frz1", 12'hC00, 32'd1000);
        rd("t4_frz2", 12'hC00, 32'd1000);
        rd("t4_inh", 12'h320, 32'd1);
        req("t4_clr", 12'h320, 3'b111, 32'd1, 1'b1, 1'b1, 1'b0,
            32'd1, 1'b0);
        rd("t4_run", 12'hC00, 32'd1001);

        // Inhibit mask, half-writes of mcycle, time pass-through
        req("tm_all", 12'h320, 3'b001, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0,
            32'd0, 1'b0);
        rd("tm_mask", 12'h320, 32'h3D);
        req("tm_clr", 12'h320, 3'b001, 32'd0, 1'b1, 1'b1, 1'b0,
            32'h3D, 1'b0);
        req("th_w", 12'hB80, 3'b001, 32'hA, 1'b1, 1'b1, 1'b0,
            32'd0, 1'b0);
        rd("th_r", 12'hB80, 32'hA);
        req("th_rc", 12'hB80, 3'b011, 32'h2, 1'b1, 1'b1, 1'b0,
            32'hA, 1'b0);
        rd("th_u", 12'hC80, 32'h8);
        rd("tt_lo", 12'hC01, 32'h9ABC_DEF0);
        rd("tt_hi", 12'hC81, 32'h1234_5678);

        // Illegal addresses / funct3, out-of-range selector
        req("t6_b06", 12'hB06, 3'b010, 32'd0, 1'b0, 1'b1, 1'b0,
            32'd0, 1'b1);
        req("t6_326", 12'h326, 3'b010, 32'd0, 1'b0, 1'b1, 1'b0,
            32'd0, 1'b1);
        req("t6_321", 12'h321, 3'b010, 32'd0, 1'b0, 1'b1, 1'b0,
            32'd0, 1'b1);
        req("t6_b01", 12'hB01, 3'b010, 32'd0, 1'b0, 1'b1, 1'b0,
            32'd0, 1'b1);
        req("t6_f0", 12'hB00, 3'b000, 32'd0, 1'b0, 1'b1, 1'b0,
            32'd0, 1'b1);
        req("t6_f4", 12'hB00, 3'b100, 32'd0, 1'b0, 1'b1, 1'b0,
            32'd0, 1'b1);
        req("t6_sel9", 12'h323, 3'b001, 32'd9, 1'b1, 1'b1, 1'b0,
            32'd1, 1'b0);
        hpm_event = 8'hFF;
        repeat (5) @(negedge clk);
        hpm_event = '0;
        rd("t6_nocnt", 12'hB03, 32'd0);
        rd("t6_rsel", 12'h323, 32'd9);
        req("t6_wide", 12'h323, 3'b001, 32'hFFFF_FFF2, 1'b1, 1'b1, 1'b0,
            32'd9, 1'b0);
        rd("t6_trunc", 12'h323, 32'd2);

        // Reset drops a request in flight
        csr_valid  = 1'b1;
        csr_addr   = 12'hB00;
        csr_funct3 = 3'b010;
        csr_src    = '0;
        csr_src_nz = 1'b0;
        csr_rd_nz  = 1'b1;
        @(negedge clk);
        csr_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("tr_drop", 64'(csr_resp_valid), 64'd0);
        chk("tr_rdata", 64'(csr_rdata), 64'd0);
        rst = 1'b0;
        rd("tr_cyc", 12'hB00, 32'd1);
        rd("tr_inh", 12'h320, 32'd0);
        rd("tr_hpm1", 12'hB04, 32'd0);
        rd("tr_sel", 12'h323, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
